// File: rtl/rsa_decrypt_pkg.sv
// Shared definitions for the RSA decryption datapath: FSM state encodings,
// the modular-reduction cycle count and the leading-zero helper used by RSA_DEC_LZ_SKIP_EN.
package rsa_decrypt_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REDC = 3'd1,
      SQ   = 3'd2,
      MUL  = 3'd3,
      NEXT = 3'd4,
      DONE = 3'd5
   } state_t;

   // One load cycle plus one shift/compare/subtract cycle per dividend bit.
   function automatic int mod_cycles(input int width);
      return 2 * width + 1;
   endfunction

   // Number of significant bits in value (0 when value is 0).
   function automatic int msb_len(input logic [31:0] value);
      int len;
      len = 0;
      for (int i = 0; i < 32; i++) begin
         if (value[i]) len = i + 1;
      end
      return len;
   endfunction

endpackage

// File: rtl/rsa_decrypt_mod_serial.sv
// Bit-serial restoring reducer: rem = dividend mod N over one load cycle plus
// 2*N_width shift/compare/subtract cycles. done is high during the final shift cycle.
module mod_serial
   import rsa_decrypt_pkg::*;
#(
   parameter int N_width = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic [2*N_width-1:0]   dividend,
   input  logic [N_width-1:0]     N,
   output logic [N_width-1:0]     rem,
   output logic                   done
);

   localparam int SHIFTS = mod_cycles(N_width) - 1;
   localparam int CW     = $clog2(SHIFTS + 1);

   logic [2*N_width-1:0] sh;
   logic [N_width-1:0]   acc;
   logic [CW-1:0]        cnt;
   logic [N_width:0]     trial;
   logic [N_width-1:0]   acc_next;

   // Partial remainder stays below N, so shifting in one bit never exceeds 2N.
   assign trial    = {acc, sh[2*N_width-1]};
   assign acc_next = (trial >= {1'b0, N}) ? N_width'(trial - {1'b0, N})
                                          : trial[N_width-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         sh  <= '0;
         acc <= '0;
         cnt <= '0;
      end else if (load) begin
         sh  <= dividend;
         acc <= '0;
         cnt <= CW'(SHIFTS);
      end else if (cnt != '0) begin
         sh  <= {sh[2*N_width-2:0], 1'b0};
         acc <= acc_next;
         cnt <= cnt - CW'(1);
      end
   end

   assign rem  = acc;
   assign done = (cnt == CW'(1));

endmodule

// File: rtl/rsa_decrypt.sv
// RSA decryption top: plain = cipher^d mod N by left-to-right square-and-multiply,
// every reduction through one mod_serial. RSA_DEC_LZ_SKIP_EN skips leading zero bits of d.
module rsa_decrypt
   import rsa_decrypt_pkg::*;
#(
   parameter int N_width    = 6,
   parameter int expo_width = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [N_width-1:0]    cipher,
   input  logic [expo_width-1:0] d,
   input  logic [N_width-1:0]    N,
   output logic [N_width-1:0]    plain,
   output logic                  valid,
   output logic                  busy
);

   localparam int W  = N_width;
   localparam int IW = $clog2(expo_width + 1);

   state_t state, state_next;

   logic [W-1:0]          cipher_r, n_r, c_r, plain_r;
   logic [expo_width-1:0] d_r;
   logic [IW-1:0]         idx_r;
   logic                  kick, launch, first;

   logic                  load, done, bit_set;
   logic [2*W-1:0]        mul_a, mul_b, dividend;
   logic [W-1:0]          rem, r_cur, one_mod;

   // idx_r counts the exponent bits still to scan; inside SQ it is the current bit index.
   assign bit_set  = |(d_r & (expo_width'(1) << idx_r));
   assign one_mod  = (n_r > W'(1)) ? W'(1) : '0;
   // R is not stored separately: it lives in the reducer until the next operand load.
   assign r_cur    = first ? one_mod : rem;
   assign dividend = mul_a * mul_b;

   mod_serial #(.N_width(W)) u_mod (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .dividend (dividend),
      .N        (n_r),
      .rem      (rem),
      .done     (done)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      mul_a      = '0;
      mul_b      = '0;
      case (state)
         IDLE, DONE: begin
            if (start) state_next = REDC;
         end
         REDC: begin
            if (kick) begin
               if (n_r == '0) state_next = NEXT;
            end else if (launch) begin
               load  = 1'b1;
               mul_a = {{W{1'b0}}, cipher_r};
               mul_b = (2*W)'(1);
            end else if (done) begin
               state_next = NEXT;
            end
         end
         NEXT: begin
            if (idx_r == '0) begin
               state_next = DONE;
            end else begin
               load       = 1'b1;
               mul_a      = {{W{1'b0}}, r_cur};
               mul_b      = {{W{1'b0}}, r_cur};
               state_next = SQ;
            end
         end
         SQ: begin
            if (done) state_next = bit_set ? MUL : NEXT;
         end
         MUL: begin
            if (launch) begin
               load  = 1'b1;
               mul_a = {{W{1'b0}}, rem};
               mul_b = {{W{1'b0}}, c_r};
            end else if (done) begin
               state_next = NEXT;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cipher_r <= '0;
         n_r      <= '0;
         c_r      <= '0;
         plain_r  <= '0;
         d_r      <= '0;
         idx_r    <= '0;
         kick     <= 1'b0;
         launch   <= 1'b0;
         first    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  cipher_r <= cipher;
                  d_r      <= d;
                  n_r      <= N;
                  plain_r  <= '0;
                  kick     <= 1'b1;
                  launch   <= 1'b0;
                  first    <= 1'b1;
`ifdef RSA_DEC_LZ_SKIP_EN
                  idx_r    <= IW'(msb_len(32'(d)));
`else
                  idx_r    <= IW'(expo_width);
`endif
               end
            end
            REDC: begin
               // The first cycle screens N==0, which bypasses every reduction.
               if (kick) begin
                  kick <= 1'b0;
                  if (n_r == '0) idx_r  <= '0;
                  else           launch <= 1'b1;
               end else if (launch) begin
                  launch <= 1'b0;
               end
            end
            NEXT: begin
               first <= 1'b0;
               if (first) c_r <= rem;
               if (idx_r == '0) plain_r <= r_cur;
               else             idx_r   <= idx_r - IW'(1);
            end
            SQ: begin
               if (done && bit_set) launch <= 1'b1;
            end
            MUL: begin
               if (launch) launch <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign plain = plain_r;
   assign valid = (state == DONE);
   assign busy  = (state != IDLE) && (state != DONE);

endmodule

// File: tb/tb_rsa_decrypt.sv
// Scoreboard bench for rsa_decrypt: driver tasks push expected plain/latency,
// a negedge monitor pops and compares on each rising valid.
module tb_rsa_decrypt;

   localparam int NW = 6;
   localparam int EW = 6;
   localparam int M  = 2 * NW + 1;
   localparam int BUDGET = 400;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [NW-1:0] tb_cipher = '0;
   logic [EW-1:0] tb_d = '0;
   logic [NW-1:0] tb_n = '0;
   logic [NW-1:0] plain;
   logic          valid;
   logic          busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic valid_prev = 1'b0;

   logic [NW-1:0] exp_q[$];
   int            lat_q[$];
   int            t0_q[$];

   rsa_decrypt dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .cipher (tb_cipher),
      .d      (tb_d),
      .N      (tb_n),
      .plain  (plain),
      .valid  (valid),
      .busy   (busy)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   function automatic int ref_pow(input int c, input int e, input int n);
      int r;
      if (n == 0) return 0;
      r = 1 % n;
      for (int i = 0; i < e; i++) r = (r * c) % n;
      return r;
   endfunction

   function automatic int bit_len(input int v);
      int len;
      len = 0;
      for (int i = 0; i < 32; i++) if (v[i]) len = i + 1;
      return len;
   endfunction

   function automatic int exp_lat(input int e, input int n);
      int scan;
      if (n == 0) return 2;
`ifdef RSA_DEC_LZ_SKIP_EN
      scan = bit_len(e);
`else
      scan = EW;
`endif
      return (1 + scan + $countones(e)) * M + 2;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rst) begin
         valid_prev = 1'b0;
      end else begin
         if (valid && !valid_prev) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_valid actual plain=%0d expected no result", plain);
            end else begin
               chk("plain", int'(plain), int'(exp_q.pop_front()));
               chk("latency", cyc - t0_q.pop_front(), lat_q.pop_front());
            end
         end
         if (!valid) chk("plain_zero_when_invalid", int'(plain), 0);
         valid_prev = valid;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_exp(input int c, input int e, input int n, input int t0);
      exp_q.push_back(NW'(ref_pow(c, e, n)));
      lat_q.push_back(exp_lat(e, n));
      t0_q.push_back(t0);
   endtask

   // One run; poke > 0 re-asserts start with fresh inputs that many cycles into the run.
   task automatic run_one(input int c, input int e, input int n, input int poke);
      int waited;
      int busy_low;
      @(negedge clk);
      tb_cipher = NW'(c);
      tb_d      = EW'(e);
      tb_n      = NW'(n);
      start     = 1'b1;
      push_exp(c, e, n, cyc + 1);
      @(negedge clk);
      start    = 1'b0;
      waited   = 0;
      busy_low = 0;
      while (!valid && waited < BUDGET) begin
         if (!busy) busy_low++;
         if (poke > 0 && waited == poke) begin
            start     = 1'b1;
            tb_cipher = NW'($urandom_range(0, 63));
            tb_d      = EW'($urandom_range(0, 63));
            tb_n      = NW'($urandom_range(0, 63));
         end else if (poke > 0 && waited == poke + 1) begin
            start = 1'b0;
         end
         @(negedge clk);
         waited++;
      end
      if (waited >= BUDGET) chk("run_timeout", waited, -1);
      else                  chk("busy_low_cycles", busy_low, 0);
      start = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int k, t, vcount, waited;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_plain", int'(plain), 0);
      chk("reset_valid", int'(valid), 0);
      chk("reset_busy", int'(busy), 0);
      rst = 1'b0;

      run_one(31, 7, 33, 0);
      run_one(63, 1, 33, 0);
      run_one(20, 0, 33, 0);
      run_one(9, 5, 1, 0);
      run_one(31, 7, 33, 20);
      run_one(17, 0, 1, 0);
      run_one(45, 63, 2, 0);

      // reset in the middle of a run
      @(negedge clk);
      tb_cipher = 6'd31; tb_d = 6'd7; tb_n = 6'd33; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (49) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrun_reset_plain", int'(plain), 0);
      chk("midrun_reset_valid", int'(valid), 0);
      chk("midrun_reset_busy", int'(busy), 0);
      rst = 1'b0;
      run_one(31, 7, 33, 0);

      run_one(50, 13, 0, 0);

      repeat (30) begin
         run_one($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(2, 63), 0);
      end

      // start held high: three back-to-back runs, period T+1
      @(negedge clk);
      tb_cipher = 6'd31; tb_d = 6'd7; tb_n = 6'd33; start = 1'b1;
      k = cyc;
      t = exp_lat(7, 33);
      for (int i = 0; i < 3; i++) push_exp(31, 7, 33, k + 1 + i * (t + 1));
      vcount = 0;
      waited = 0;
      while (vcount < 2 && waited < 3 * BUDGET) begin
         @(negedge clk);
         waited++;
         if (valid) vcount++;
      end
      @(negedge clk);
      start = 1'b0;
      while (vcount < 3 && waited < 3 * BUDGET) begin
         @(negedge clk);
         waited++;
         if (valid) vcount++;
      end
      chk("held_start_valid_pulses", vcount, 3);

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rsa_decrypt.md
Name: rsa_decrypt

Overview:
- Decryption end of the RSA datapath: computes plain = cipher^d mod N using left-to-right binary square-and-multiply.
- Sits downstream of the encryption top. It consumes the ciphertext that the encryptor produces (valid/result) and returns the recovered message.
- All modular reductions run through one bit-serial restoring reducer. No DSP and no BRAM are used.
- Uses the same start/valid convention as the encryption top: level start, and valid is held until the next accepted start.

Parameters:
- N_width, 6, width of modulus N, cipher and plain.
- expo_width, 6, width of private exponent d.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on every edge while idle or done.
- cipher  input  N_width  ciphertext; may be >= N.
- d  input  expo_width  private exponent.
- N  input  N_width  modulus.
- plain  output  N_width  result; reads 0 whenever valid=0.
- valid  output  1  result ready; level signal.
- busy  output  1  high while a computation is in progress.

Behaviour:
- Reset: state=IDLE; plain=0, valid=0, busy=0; all internal registers cleared.
- Reset has priority over everything, including mid-operation: the run aborts and no valid is raised.
- Start acceptance:
  - start=1 in IDLE or DONE captures cipher, d and N into registers, clears valid, and sets busy on the next edge.
  - start=1 while busy is ignored.
  - Inputs may change after capture without affecting the run.
- Mod reduction unit:
  - Reduces a 2*N_width-bit dividend modulo N.
  - Takes M = 2*N_width+1 cycles: 1 load cycle plus 2*N_width shift/compare/subtract cycles.
  - Multiplier is a full N_width x N_width product, width 2*N_width, with no truncation.
- States:
  - IDLE.
  - REDC: computes C = cipher mod N; R = 1.
  - SQ: computes R = R*R mod N.
  - MUL: computes R = R*C mod N; entered only when the current bit of d is 1.
  - NEXT: decrements the bit index; goes to DONE after bit 0.
  - DONE: valid=1, busy=0, plain=R; held until the next accepted start or rst.
- Bit scan order is MSB (expo_width-1) down to 0.
- Latency from the start-capture edge to valid=1: T = (1 + expo_width + popcount(d))*M + 2 cycles. This is exact and data-dependent only through popcount(d).
- Boundary cases:
  - N==1: plain=0, full latency.
  - d==0: plain = 1 mod N, i.e. 1, or 0 when N==1.
  - N==0: no reduction performed; DONE is reached after the 2-cycle overhead only, with plain=0.
  - start held high continuously: restarts every time DONE is reached. valid is high for exactly 1 cycle per run, because the restart edge clears it.

Optional Feature:
- Macro: RSA_DEC_LZ_SKIP_EN.
- Defined: leading zero bits of d are skipped before the first SQ; the scan starts at the highest set bit. Latency becomes T = (1 + L + popcount(d))*M + 2, where L = index of the MSB set + 1 (L=0 when d==0).
- Undefined: all expo_width bits are scanned, and the fixed-structure latency above applies.
- Results are identical in both builds.

Decomposition:
- Shared header rsa_dec_defs.vh holds:
  - state encodings (IDLE, REDC, SQ, MUL, NEXT, DONE);
  - the M cycle-count expression.
- Sub-module mod_serial (parameter N_width):
  - Ports: clk, rst, load, dividend[2*N_width-1:0], N, rem[N_width-1:0], done.
  - Restoring shift-subtract reducer; the top instantiates exactly one.

Test Plan:
- N=33, d=7, cipher=31 (N_width=6, expo_width=6) -> plain=4, valid exactly at T=132 (93 with RSA_DEC_LZ_SKIP_EN); busy high throughout.
- N=33, d=1, cipher=63 (>=N) -> plain=30; d=0, cipher=20 -> plain=1; N=1, d=5, cipher=9 -> plain=0.
- Start pulse with N=33, d=7, cipher=31; toggle start at cycle 20 and change all inputs mid-run -> start ignored, result still 4.
- rst asserted at cycle 50 of a run -> valid=0, plain=0, busy=0 next edge; new start afterwards gives the correct result.
- Random sweep, N in 2..63, all d, cipher, compared against the reference model pow(cipher,d) mod N; also check that plain reads 0 while valid=0.
- N=0 -> plain=0, valid at T=2; start held high -> valid pulses 1 cycle per run, with period T+1.
